// File: rtl/fp_adder_arbiter.sv
// Round-robin front end sharing one combinational FP32 adder between two
// requesters. Operands are latched and held for EXEC_CYCLES, then the sum is
// registered and returned on a single tagged response channel.

module adderunit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic        a_nan, b_nan, a_inf, b_inf, rup;
   logic [31:0] big, sml;
   logic [7:0]  el, es, d;
   logic [26:0] ml, ms, msh;
   logic [27:0] sum;
   logic [8:0]  e;
   logic [24:0] rnd;

   // Align smaller magnitude, add/subtract, normalise, round to nearest even
   always_comb begin
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      big = a;
      sml = b;
      if (b[30:0] > a[30:0]) begin
         big = b;
         sml = a;
      end
      // subnormals use exponent 1 with no hidden bit
      el  = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      es  = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      ml  = {big[30:23] != 8'd0, big[22:0], 3'b000};
      ms  = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
      d   = el - es;
      if (d > 8'd26)
         msh = {26'd0, |ms};
      else
         msh = (ms >> d) | {26'd0, |(ms & ~(27'h7FFFFFF << d))};
      if (big[31] != sml[31])
         sum = {1'b0, ml} - {1'b0, msh};
      else
         sum = {1'b0, ml} + {1'b0, msh};
      e = {1'b0, el};
      if (sum[27]) begin
         sum = {1'b0, sum[27:2], sum[1] | sum[0]};
         e   = e + 9'd1;
      end
      for (int i = 0; i < 26; i++) begin
         if (!sum[26] && (e > 9'd1)) begin
            sum = sum << 1;
            e   = e - 9'd1;
         end
      end
      rup = sum[2] && (sum[3] || sum[1] || sum[0]);
      rnd = {1'b0, sum[26:3]} + {24'd0, rup};
      if (rnd[24])
         e = e + 9'd1;
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
         y = 32'h7FC00000;
      else if (a_inf)
         y = a;
      else if (b_inf)
         y = b;
      else if (sum == 28'd0)
         y = {a[31] & b[31], 31'd0};
      else if (e >= 9'd255)
         y = {big[31], 8'hFF, 23'd0};
      else
         y = {big[31], (rnd[24] || rnd[23]) ? e[7:0] : 8'd0,
              rnd[24] ? 23'd0 : rnd[22:0]};
   end
endmodule

module fp_adder_arbiter #(
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic             req1_sub,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [31:0]      resp_data,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   state_t           state_q, state_d;
   logic [31:0]      opa_q, opa_d, opb_q, opb_d, resp_data_q, resp_data_d, sum;
   logic [3:0]       cnt_q, cnt_d;
   logic             id_q, id_d, last_q, last_d;
   logic             resp_valid_q, resp_valid_d, resp_id_q, resp_id_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;
   logic             grant1, idle_ok;

   adderunit u_add (.a(opa_q), .b(opb_q), .y(sum));

   // port 1 wins when alone or when port 0 was served last
   assign grant1     = req1_valid && (!req0_valid || !last_q);
   assign idle_ok    = rst_n && (state_q == IDLE);
   assign req0_ready = idle_ok && req0_valid && !grant1;
   assign req1_ready = idle_ok && grant1;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign busy       = (state_q != IDLE);
   assign op_count   = op_count_q;

   // Next-state: accept in IDLE, count down in EXEC, wait for handshake in RESP
   always_comb begin
      state_d      = state_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      cnt_d        = cnt_q;
      id_d         = id_q;
      last_d       = last_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      op_count_d   = op_count_q;
      case (state_q)
         IDLE: begin
            if (req0_ready) begin
               opa_d   = req0_a;
               opb_d   = {req0_b[31] ^ req0_sub, req0_b[30:0]};
               id_d    = 1'b0;
               last_d  = 1'b0;
               cnt_d   = CNT_INIT;
               state_d = EXEC;
            end else if (req1_ready) begin
               opa_d   = req1_a;
               opb_d   = {req1_b[31] ^ req1_sub, req1_b[30:0]};
               id_d    = 1'b1;
               last_d  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               resp_data_d  = sum;
               resp_id_d    = id_q;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               op_count_d   = op_count_q + 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight work
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         opa_q        <= '0;
         opb_q        <= '0;
         cnt_q        <= '0;
         id_q         <= 1'b0;
         last_q       <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         cnt_q        <= cnt_d;
         id_q         <= id_d;
         last_q       <= last_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         op_count_q   <= op_count_d;
      end
   end
endmodule
